// File: rtl/synth_pkg.sv
// Shared widths, legal key ranges, allocator FSM states and the captured key-event payload.
package synth_pkg;

    localparam int unsigned NOTE_W = 4;
    localparam int unsigned OCT_W  = 3;

    localparam logic [NOTE_W-1:0] NOTE_MIN  = NOTE_W'(1);
    localparam logic [NOTE_W-1:0] NOTE_MAX  = NOTE_W'(13);
    localparam logic [OCT_W-1:0]  OCT_MIN   = OCT_W'(1);
    localparam logic [OCT_W-1:0]  OCT_MAX   = OCT_W'(5);
    localparam logic [OCT_W-1:0]  OCT_RESET = OCT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [OCT_W-1:0]  octave;
        logic              rel;
    } key_ev_t;

    function automatic logic ev_legal(input key_ev_t ev);
        return (ev.note >= NOTE_MIN) && (ev.note <= NOTE_MAX) &&
               (ev.octave >= OCT_MIN) && (ev.octave <= OCT_MAX);
    endfunction

endpackage

// File: rtl/voice_find.sv
// Combinational voice search: active match, lowest free voice and the oldest (highest-rank) voice.
module voice_find
    import synth_pkg::*;
#(
    parameter  int unsigned NUM_VOICES = 4,
    localparam int unsigned IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic [NUM_VOICES-1:0]        active,
    input  logic [NOTE_W*NUM_VOICES-1:0] notes,
    input  logic [OCT_W*NUM_VOICES-1:0]  octaves,
    input  logic [IDX_W*NUM_VOICES-1:0]  ranks,
    input  key_ev_t                      ev,
    output logic                         match_hit,
    output logic [IDX_W-1:0]             match_idx,
    output logic                         free_hit,
    output logic [IDX_W-1:0]             free_idx,
    output logic [IDX_W-1:0]             oldest_idx
);

    // Scan high to low so the lowest qualifying index wins.
    always_comb begin
        match_hit  = 1'b0;
        match_idx  = '0;
        free_hit   = 1'b0;
        free_idx   = '0;
        oldest_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (active[i] &&
                (notes[i*NOTE_W +: NOTE_W] == ev.note) &&
                (octaves[i*OCT_W +: OCT_W] == ev.octave)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!active[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (ranks[i*IDX_W +: IDX_W] == IDX_W'(NUM_VOICES - 1)) begin
                oldest_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Key-event to tone-voice allocator with LRU ranking; a full pool drops the press
// unless VOICE_STEAL_EN is defined, in which case the oldest voice is stolen.
module voice_alloc
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [OCT_W-1:0]             ev_octave,
    input  logic                         ev_release,
    input  logic                         all_off,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
    output logic [OCT_W*NUM_VOICES-1:0]  voice_octave,
    output logic [NUM_VOICES-1:0]        voice_start,
    output logic                         ev_drop
);

    localparam int unsigned IDX_W     = $clog2(NUM_VOICES);
    localparam int unsigned RANK_BITS = IDX_W * NUM_VOICES;

    function automatic logic [RANK_BITS-1:0] rank_init();
        logic [RANK_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            r[i*IDX_W +: IDX_W] = IDX_W'(i);
        end
        return r;
    endfunction

    state_t                       state_q, state_d;
    key_ev_t                      ev_q;
    logic                         accept_c;
    logic [RANK_BITS-1:0]         ranks_q, ranks_d;

    logic                         match_hit_c, free_hit_c;
    logic [IDX_W-1:0]             match_idx_c, free_idx_c, oldest_idx_c;
    logic                         legal_q, match_hit_q, free_hit_q;
    logic [IDX_W-1:0]             match_idx_q, free_idx_q;
`ifdef VOICE_STEAL_EN
    logic [IDX_W-1:0]             oldest_idx_q;
`else
    logic                         unused_oldest;
    assign unused_oldest = ^oldest_idx_c;
`endif

    logic [NUM_VOICES-1:0]        active_d, start_d;
    logic [NOTE_W*NUM_VOICES-1:0] note_d;
    logic [OCT_W*NUM_VOICES-1:0]  oct_d;
    logic                         drop_d;
    logic                         trig;
    logic                         load;
    logic [IDX_W-1:0]             trig_idx;
    logic [IDX_W-1:0]             trig_rank;

    assign ev_ready = (state_q == IDLE);
    assign accept_c = ev_valid && ev_ready && !all_off;

    voice_find #(
        .NUM_VOICES (NUM_VOICES)
    ) u_find (
        .active     (voice_active),
        .notes      (voice_note),
        .octaves    (voice_octave),
        .ranks      (ranks_q),
        .ev         (ev_q),
        .match_hit  (match_hit_c),
        .match_idx  (match_idx_c),
        .free_hit   (free_hit_c),
        .free_idx   (free_idx_c),
        .oldest_idx (oldest_idx_c)
    );

    // FSM next state; all_off overrides any in-flight event.
    always_comb begin
        state_d = state_q;
        if (all_off) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept_c) state_d = LOOKUP;
                LOOKUP:  state_d = COMMIT;
                COMMIT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Commit decision and next voice state.
    always_comb begin
        active_d  = voice_active;
        note_d    = voice_note;
        oct_d     = voice_octave;
        ranks_d   = ranks_q;
        start_d   = '0;
        drop_d    = 1'b0;
        trig      = 1'b0;
        load      = 1'b0;
        trig_idx  = '0;
        trig_rank = '0;

        if ((state_q == COMMIT) && !all_off) begin
            if (!legal_q) begin
                drop_d = 1'b1;
            end else if (ev_q.rel) begin
                if (match_hit_q) active_d[match_idx_q] = 1'b0;
            end else if (match_hit_q) begin
                trig     = 1'b1;
                trig_idx = match_idx_q;
            end else if (free_hit_q) begin
                trig     = 1'b1;
                load     = 1'b1;
                trig_idx = free_idx_q;
            end else begin
`ifdef VOICE_STEAL_EN
                trig     = 1'b1;
                load     = 1'b1;
                trig_idx = oldest_idx_q;
`else
                drop_d   = 1'b1;
`endif
            end
        end

        if (trig) begin
            active_d[trig_idx] = 1'b1;
            start_d[trig_idx]  = 1'b1;
            if (load) begin
                note_d[trig_idx*NOTE_W +: NOTE_W] = ev_q.note;
                oct_d[trig_idx*OCT_W +: OCT_W]    = ev_q.octave;
            end
            // Triggered voice becomes newest; voices that were newer age by one.
            trig_rank = ranks_q[trig_idx*IDX_W +: IDX_W];
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == trig_idx) begin
                    ranks_d[i*IDX_W +: IDX_W] = '0;
                end else if (ranks_q[i*IDX_W +: IDX_W] < trig_rank) begin
                    ranks_d[i*IDX_W +: IDX_W] = ranks_q[i*IDX_W +: IDX_W] + IDX_W'(1);
                end
            end
        end

        if (all_off) active_d = '0;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            ev_q         <= '0;
            legal_q      <= 1'b0;
            match_hit_q  <= 1'b0;
            match_idx_q  <= '0;
            free_hit_q   <= 1'b0;
            free_idx_q   <= '0;
`ifdef VOICE_STEAL_EN
            oldest_idx_q <= '0;
`endif
            voice_active <= '0;
            voice_note   <= '0;
            voice_octave <= {NUM_VOICES{OCT_RESET}};
            ranks_q      <= rank_init();
            voice_start  <= '0;
            ev_drop      <= 1'b0;
        end else begin
            if (accept_c) begin
                ev_q.note   <= ev_note;
                ev_q.octave <= ev_octave;
                ev_q.rel    <= ev_release;
            end
            if (state_q == LOOKUP) begin
                legal_q      <= ev_legal(ev_q);
                match_hit_q  <= match_hit_c;
                match_idx_q  <= match_idx_c;
                free_hit_q   <= free_hit_c;
                free_idx_q   <= free_idx_c;
`ifdef VOICE_STEAL_EN
                oldest_idx_q <= oldest_idx_c;
`endif
            end
            voice_active <= active_d;
            voice_note   <= note_d;
            voice_octave <= oct_d;
            ranks_q      <= ranks_d;
            voice_start  <= start_d;
            ev_drop      <= drop_d;
        end
    end

endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of tone-generator voices shared among key events (legal 2..8).
REQ-002 clock  input  1  single system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 ev_valid  input  1  key event offered.
REQ-005 ev_ready  output  1  allocator idle and able to accept an event.
REQ-006 ev_note  input  4  semitone index; legal range 1..13.
REQ-007 ev_octave  input  3  octave; legal range 1..5.
REQ-008 ev_release  input  1  0 = key press (make), 1 = key release (break).
REQ-009 all_off  input  1  synchronous request to silence every voice.
REQ-010 voice_active  output  NUM_VOICES  per-voice gate level.
REQ-011 voice_note  output  4*NUM_VOICES  per-voice note; voice i occupies bits [4i+3:4i].
REQ-012 voice_octave  output  3*NUM_VOICES  per-voice octave; voice i occupies bits [3i+2:3i].
REQ-013 voice_start  output  NUM_VOICES  one-cycle pulse when a voice is (re)triggered.
REQ-014 ev_drop  output  1  one-cycle pulse when an accepted event is discarded.

Function
REQ-015 FSM states IDLE, LOOKUP, COMMIT; IDLE->LOOKUP on ev_valid&&ev_ready; LOOKUP->COMMIT unconditionally; COMMIT->IDLE unconditionally.
REQ-016 ev_ready SHALL be 1 only in IDLE; the event fields SHALL be captured into a register on the accepting edge, so they may change afterwards.
REQ-017 Event accepted at edge T: LOOKUP computes match/free/oldest from captured fields; voice outputs, voice_start and ev_drop SHALL update at edge T+2; ev_ready SHALL be high again after edge T+2.
REQ-018 Each voice holds a rank 0..NUM_VOICES-1 (0 = most recently triggered); ranks SHALL always form a permutation.
REQ-019 Press of a note/octave already active in voice k: retrigger k (voice_start[k] pulse, rank k to 0, ranks previously below k's incremented).
REQ-020 Press, no match, a free voice exists: allocate lowest-index free voice, load note/octave, set active, pulse voice_start, rank update as REQ-019.
REQ-021 Press, no match, no free voice: behaviour per REQ-029/REQ-030.
REQ-022 Release matching active voice k: clear voice_active[k]; note/octave/rank retained; no pulses.
REQ-023 Release with no match: no state change, no ev_drop.
REQ-024 Illegal event (note 0 or 14..15, octave 0 or 6..7): no voice change, ev_drop pulse at T+2.
REQ-025 all_off=1 in any cycle: at that edge clear all voice_active, force FSM to IDLE, suppress any pending COMMIT (no voice_start, no ev_drop); all_off takes priority over a simultaneous ev_valid, which SHALL NOT be accepted that cycle.
REQ-026 At most one voice_start bit SHALL be high in any cycle.

Reset
REQ-027 rst low SHALL immediately force: FSM IDLE, voice_active 0, voice_note 0, voice_octave 1 per voice, rank[i]=i, voice_start 0, ev_drop 0; ev_ready SHALL read 1 while in reset.
REQ-028 Reset asserted mid-operation SHALL abandon the captured event with no pulse after release.

Configuration
REQ-029 Macro VOICE_STEAL_EN defined: with no free voice, steal the voice of highest rank, load new note/octave, keep active, pulse voice_start, rank to 0.
REQ-030 VOICE_STEAL_EN undefined: with no free voice, discard press and pulse ev_drop; rank logic for stealing SHALL not be required.

Structure
REQ-031 Package synth_pkg SHALL hold NOTE_W=4, OCT_W=3, NOTE_MIN=1, NOTE_MAX=13, OCT_MIN=1, OCT_MAX=5, OCT_RESET=1 and the FSM state enum.
REQ-032 Sub-module voice_find (combinational): inputs active, notes, octaves, ranks, captured event; outputs match_hit/match_idx, free_hit/free_idx (lowest index), oldest_idx.

Verification
REQ-033 Reset, press note 1 oct 1 -> voice 0 active, voice_start=0001 at T+2, ev_ready low 2 cycles.
REQ-034 Press notes 1,3,5,6 oct 2 then note 8 -> with VOICE_STEAL_EN voice 0 gets note 8, start=0001; without, ev_drop pulse, voices unchanged.
REQ-035 Press note 5 oct 3 twice -> second press retriggers same voice, no second voice active.
REQ-036 Press note 12 oct 4, release note 12 oct 4, release note 2 oct 4 -> voice cleared, second release no change and no ev_drop.
REQ-037 Press note 14 oct 1 and note 1 oct 6 -> ev_drop each, voice_active stays 0.
REQ-038 all_off asserted in COMMIT cycle of a press -> voice_active 0, no voice_start, ev_ready 1 next cycle; rst pulse during LOOKUP -> reset values, no pulses.
